// File: rtl/x_pll_rst_seq_if.sv
// x_pll_rst_seq_if: lock/restart inputs and reset/status outputs of the PLL reset sequencer
interface x_pll_rst_seq_if;
    logic       i_lock;
    logic       i_restart;
    logic       o_pll_nrst;
    logic       o_dl_rst;
    logic       o_ready;
    logic       o_fail;
    logic [3:0] o_retry_cnt;
    logic [7:0] o_loss_cnt;
    modport master (
        output i_lock, i_restart,
        input  o_pll_nrst, o_dl_rst, o_ready, o_fail, o_retry_cnt, o_loss_cnt
    );
    modport slave (
        input  i_lock, i_restart,
        output o_pll_nrst, o_dl_rst, o_ready, o_fail, o_retry_cnt, o_loss_cnt
    );
endinterface

// File: rtl/x_pll_rst_seq.sv
// x_pll_rst_seq: PLL reset/lock sequencer with timeout retries and stable-lock release of delay-line reset
module x_pll_rst_seq #(
    parameter int P_HOLD_CYCLES   = 16,
    parameter int P_LOCK_TIMEOUT  = 1200,
    parameter int P_STABLE_CYCLES = 64,
    parameter int P_MAX_RETRY     = 3
) (
    input  logic           i_clk,
    input  logic           i_rst,
    x_pll_rst_seq_if.slave bus
);
    localparam int MAX_HS = P_HOLD_CYCLES > P_STABLE_CYCLES ? P_HOLD_CYCLES : P_STABLE_CYCLES;
    localparam int MAXC   = P_LOCK_TIMEOUT > MAX_HS ? P_LOCK_TIMEOUT : MAX_HS;
    localparam int CW     = MAXC > 1 ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] HOLD_END = CW'(P_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] TO_END   = CW'(P_LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_END  = CW'(P_STABLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_MAX = 4'(P_MAX_RETRY);

    typedef enum logic [2:0] {S_HOLD, S_WAIT, S_STABLE, S_RUN, S_FAIL} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sync_q, sync_d;
    logic [3:0]    retry_q, retry_d;
    logic [7:0]    loss_q, loss_d;
    logic          pll_nrst_q, pll_nrst_d;
    logic          dl_rst_q, dl_rst_d;
    logic          ready_q, ready_d;
    logic          fail_q, fail_d;
    logic          lock_s;

    assign lock_s          = sync_q[1];
    assign bus.o_pll_nrst  = pll_nrst_q;
    assign bus.o_dl_rst    = dl_rst_q;
    assign bus.o_ready     = ready_q;
    assign bus.o_fail      = fail_q;
    assign bus.o_retry_cnt = retry_q;
    assign bus.o_loss_cnt  = loss_q;

    // next state, shared counter, retry/loss counters; outputs decoded from the next state so they flop with it
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        sync_d  = {sync_q[0], bus.i_lock};
        if (bus.i_restart) begin
            state_d = S_HOLD;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    cnt_d   = cnt_q == HOLD_END ? '0 : cnt_q + 1'b1;
                    state_d = cnt_q == HOLD_END ? S_WAIT : S_HOLD;
                end
                S_WAIT: begin
                    if (lock_s) begin
                        state_d = S_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TO_END) begin
                        cnt_d   = '0;
                        state_d = retry_q == RETRY_MAX ? S_FAIL : S_HOLD;
                        retry_d = retry_q == RETRY_MAX ? retry_q : retry_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!lock_s) begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q == STB_END ? '0 : cnt_q + 1'b1;
                        state_d = cnt_q == STB_END ? S_RUN : S_STABLE;
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        state_d = S_HOLD;
                        cnt_d   = '0;
                        retry_d = '0;
                        loss_d  = loss_q == 8'hFF ? loss_q : loss_q + 1'b1;
                    end
                end
                S_FAIL: state_d = S_FAIL;
                default: begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end
            endcase
        end
        pll_nrst_d = !(state_d == S_HOLD || state_d == S_FAIL);
        dl_rst_d   = state_d != S_RUN;
        ready_d    = state_d == S_RUN;
        fail_d     = state_d == S_FAIL;
    end

    // state, counters, synchroniser and all outputs registered together
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_HOLD;
            cnt_q      <= '0;
            sync_q     <= '0;
            retry_q    <= '0;
            loss_q     <= '0;
            pll_nrst_q <= 1'b0;
            dl_rst_q   <= 1'b1;
            ready_q    <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sync_q     <= sync_d;
            retry_q    <= retry_d;
            loss_q     <= loss_d;
            pll_nrst_q <= pll_nrst_d;
            dl_rst_q   <= dl_rst_d;
            ready_q    <= ready_d;
            fail_q     <= fail_d;
        end
    end
endmodule

// File: tb/tb_x_pll_rst_seq.sv
// tb_x_pll_rst_seq: vector table plus hand sequences for priority and loss-counter saturation
module tb_x_pll_rst_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    x_pll_rst_seq_if bus ();
    x_pll_rst_seq dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    typedef struct {
        int         n;
        logic       lock;
        logic       restart;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int n, logic lk, logic rs, logic nrst, logic dl, logic rdy,
                                logic fl, logic [3:0] rt, logic [7:0] ls);
        vec_t v;
        v.n       = n;
        v.lock    = lk;
        v.restart = rs;
        v.exp     = {nrst, dl, rdy, fl, rt, ls};
        return v;
    endfunction

    function automatic logic [15:0] obs();
        return {bus.o_pll_nrst, bus.o_dl_rst, bus.o_ready, bus.o_fail, bus.o_retry_cnt, bus.o_loss_cnt};
    endfunction

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(string name, logic [15:0] exp);
        logic [15:0] got;
        got = obs();
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got nrst,dl,rdy,fail=%b retry=%0d loss=%0d, want nrst,dl,rdy,fail=%b retry=%0d loss=%0d",
                     name, got[15:12], got[11:8], got[7:0], exp[15:12], exp[11:8], exp[7:0]);
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (bus.o_ready) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    initial begin
        bit ok;
        bus.i_lock    = 1'b0;
        bus.i_restart = 1'b0;
        // nominal lock
        vecs.push_back(mk(15,   0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1,    0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(66,   1, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1,    1, 0, 1, 0, 1, 0, 0, 0));
        // lock loss in RUN, relock
        vecs.push_back(mk(2,    0, 0, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1,    0, 0, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(15,   1, 0, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1,    1, 0, 1, 1, 0, 0, 0, 1));
        vecs.push_back(mk(64,   1, 0, 1, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1,    1, 0, 1, 0, 1, 0, 0, 1));
        // glitch 40 cycles into STABLE
        vecs.push_back(mk(2,    0, 0, 1, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1,    0, 0, 0, 1, 0, 0, 0, 2));
        vecs.push_back(mk(16,   1, 0, 1, 1, 0, 0, 0, 2));
        vecs.push_back(mk(1,    1, 0, 1, 1, 0, 0, 0, 2));
        vecs.push_back(mk(40,   1, 0, 1, 1, 0, 0, 0, 2));
        vecs.push_back(mk(3,    0, 0, 1, 1, 0, 0, 0, 2));
        vecs.push_back(mk(66,   1, 0, 1, 1, 0, 0, 0, 2));
        vecs.push_back(mk(1,    1, 0, 1, 0, 1, 0, 0, 2));
        // lose lock for good: four timeouts then FAIL
        vecs.push_back(mk(2,    0, 0, 1, 0, 1, 0, 0, 2));
        vecs.push_back(mk(1,    0, 0, 0, 1, 0, 0, 0, 3));
        for (int r = 0; r < 4; r++) begin
            vecs.push_back(mk(15,   0, 0, 0, 1, 0, 0, 4'(r), 3));
            vecs.push_back(mk(1,    0, 0, 1, 1, 0, 0, 4'(r), 3));
            vecs.push_back(mk(1199, 0, 0, 1, 1, 0, 0, 4'(r), 3));
            if (r < 3) vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 4'(r + 1), 3));
            else       vecs.push_back(mk(1, 0, 0, 0, 1, 0, 1, 4'd3, 3));
        end
        vecs.push_back(mk(5000, 0, 0, 0, 1, 0, 1, 3, 3));
        vecs.push_back(mk(50,   1, 0, 0, 1, 0, 1, 3, 3));
        // restart out of FAIL, then restart again mid-HOLD
        vecs.push_back(mk(1,    1, 1, 0, 1, 0, 0, 0, 3));
        vecs.push_back(mk(5,    1, 0, 0, 1, 0, 0, 0, 3));
        vecs.push_back(mk(1,    1, 1, 0, 1, 0, 0, 0, 3));
        vecs.push_back(mk(15,   1, 0, 0, 1, 0, 0, 0, 3));
        vecs.push_back(mk(1,    1, 0, 1, 1, 0, 0, 0, 3));
        vecs.push_back(mk(64,   1, 0, 1, 1, 0, 0, 0, 3));
        vecs.push_back(mk(1,    1, 0, 1, 0, 1, 0, 0, 3));

        step(3);
        check("reset", 16'h4000);
        rst = 1'b0;

        foreach (vecs[i]) begin
            bus.i_lock    = vecs[i].lock;
            bus.i_restart = vecs[i].restart;
            step(1);
            bus.i_restart = 1'b0;
            step(vecs[i].n - 1);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // reset and restart together while in RUN: reset wins, loss count clears
        bus.i_restart = 1'b1;
        rst           = 1'b1;
        step(1);
        check("rst_over_restart", 16'h4000);
        rst           = 1'b0;
        bus.i_restart = 1'b0;

        // repeated losses saturate the loss counter at 255
        for (int i = 1; i <= 300; i++) begin
            wait_ready(ok);
            if (!ok) begin
                nvec++;
                nerr++;
                $display("FAIL sat_wait%0d: got o_ready=0 after 200 cycles, want o_ready=1", i);
                break;
            end
            bus.i_lock = 1'b0;
            step(3);
            check($sformatf("sat%0d", i), {4'b0100, 4'd0, 8'(i > 255 ? 255 : i)});
            bus.i_lock = 1'b1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
